line_rr_arbiter: RTL and testbench
==================================

// Module: line_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 256-bit line port to L2/memory among NUM_REQ cache requesters (I$, D$, ...).
//  Captures the winning request into registers, holds the downstream command until mem_resp,
//  and returns a one-cycle registered response with the read line to the granted requester only.
// PARAMETERS
//  NUM_REQ  2    number of requesters; index 0 has first priority after reset
//  ADDR_W   27   line address (tag+index) width
//  LINE_W   256  cache line width
//  CNT_W    16   grant counter width (only with ARB_GRANT_CNT_EN)
// PORTS
//  clk          in   1               clock, all state updates on rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  req_read     in   NUM_REQ         per-requester line read request (level, held until req_resp)
//  req_write    in   NUM_REQ         per-requester line write request (level, held until req_resp)
//  req_addr     in   NUM_REQ*ADDR_W  flattened line addresses, slice i = requester i
//  req_wdata    in   NUM_REQ*LINE_W  flattened write lines
//  req_resp     out  NUM_REQ         one-hot, one-cycle completion pulse
//  req_rdata    out  LINE_W          registered read line, valid while req_resp != 0
//  mem_read     out  1               downstream read command (registered)
//  mem_write    out  1               downstream write command (registered)
//  mem_addr     out  ADDR_W          downstream line address (registered)
//  mem_wdata    out  LINE_W          downstream write line (registered)
//  mem_resp     in   1               downstream completion, one cycle
//  mem_rdata    in   LINE_W          downstream read line, valid with mem_resp
//  grant_count  out  NUM_REQ*CNT_W   per-requester grant counters (only with ARB_GRANT_CNT_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, rr pointer=0, all outputs 0. Mid-transaction reset drops
//    mem_read/mem_write immediately; downstream must tolerate the abort; no req_resp is issued.
//  - FSM states IDLE, BUSY, RESP.
//  - IDLE: request i pending if req_read[i]|req_write[i]. Winner = first pending index searching
//    ptr, ptr+1, ... mod NUM_REQ. On an edge with a winner: latch index g, addr, wdata and op;
//    mem_read/mem_write high from the next cycle; ptr <= (g+1) mod NUM_REQ; go BUSY.
//    No pending request: remain IDLE, outputs hold 0.
//  - Op select: req_write[g] wins if req_read[g] and req_write[g] are both high (illegal, write assumed).
//  - BUSY: mem_* held stable; requester inputs ignored (changes do not alter command).
//    On edge with mem_resp=1: mem_read/mem_write <= 0, req_rdata <= mem_rdata (reads; 0 for writes),
//    req_resp[g] <= 1, go RESP. mem_resp in IDLE/RESP is ignored.
//  - RESP: exactly one cycle; req_resp[g]=1, req_rdata valid; requester must drop its request in
//    this cycle. Next edge: req_resp <= 0, go IDLE. No grant made in RESP (stale request protection).
//  - Latency: request high before edge k -> mem cmd cycle k+1; mem_resp at edge m -> req_resp cycle m+1.
//    Min turnaround between grants: 3 cycles with zero-wait memory.
//  - Fairness: requester continuously asserting cannot be granted twice while another is pending.
//  - mem_addr/mem_wdata return to 0 outside BUSY.
// CONFIGURATION
//  ARB_GRANT_CNT_EN defined: grant_count slice i increments at each IDLE->BUSY grant to i,
//    saturates at 2^CNT_W-1, cleared by reset. Undefined: port grant_count absent, no counters.
// TESTING
//  1 Single read req 0 addr 27'h123, mem_resp after 4 cycles with data D -> mem_read 1 for 4 cycles,
//    mem_addr=27'h123, req_resp=2'b01 one cycle, req_rdata=D.
//  2 Req 0 and 1 both read from reset, held -> grant order 0,1,0,1; each req_resp one-hot correct.
//  3 Req 1 write addr 27'h7, wdata W, mem_resp immediate -> mem_write=1, mem_wdata=W one cycle,
//    req_resp=2'b10, req_rdata=0.
//  4 Requester changes req_addr during BUSY -> mem_addr unchanged until mem_resp.
//  5 rst_n low mid-BUSY -> mem_read=0 same cycle, req_resp=0, ptr=0; after release req 1 alone
//    granted normally.
//  6 ARB_GRANT_CNT_EN, CNT_W=2, 5 grants to req 0 -> grant_count[0]=3 (saturated).

Source files
------------

// File: rtl/line_rr_arbiter.sv
// Round-robin arbiter that shares one cache-line port to L2/memory among NUM_REQ requesters.
// Optional per-requester grant counters are built when ARB_GRANT_CNT_EN is defined.
module line_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 27,
    parameter int LINE_W  = 256
`ifdef ARB_GRANT_CNT_EN
    ,parameter int CNT_W  = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LINE_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_resp,
    output logic [LINE_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [LINE_W-1:0]           mem_rdata
`ifdef ARB_GRANT_CNT_EN
    ,output logic [NUM_REQ*CNT_W-1:0]   grant_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt;
    logic [PTR_W-1:0]   win_idx;
    logic               win_vld;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] gnt_oh;

    assign pending = req_read | req_write;

    // Scan from the highest offset down so the entry closest to ptr is the last one written.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_W'(idx);
            if (pending[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh      = '0;
        gnt_oh[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            req_resp  <= '0;
            req_rdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt       <= win_idx;
                        mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[win_idx*LINE_W +: LINE_W];
                        // A simultaneous read+write is illegal; treat it as a write.
                        mem_write <= req_write[win_idx];
                        mem_read  <= ~req_write[win_idx];
                        ptr       <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        req_rdata <= mem_write ? '0 : mem_rdata;
                        req_resp  <= gnt_oh;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // No grant here: the requester is still dropping its request this cycle.
                    req_resp  <= '0;
                    req_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (state == IDLE && win_vld &&
                     grant_count[win_idx*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
            grant_count[win_idx*CNT_W +: CNT_W] <= grant_count[win_idx*CNT_W +: CNT_W] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_line_rr_arbiter.sv
// Self-checking bench for line_rr_arbiter: transaction-level model plus directed scenarios.
module tb_line_rr_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 27;
    localparam int LINE_W  = 256;
`ifdef ARB_GRANT_CNT_EN
    localparam int CNT_W   = 2;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_read, req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_resp;
    logic [LINE_W-1:0]         req_rdata;
    logic                      mem_read, mem_write, mem_resp;
    logic [ADDR_W-1:0]         mem_addr;
    logic [LINE_W-1:0]         mem_wdata, mem_rdata;
`ifdef ARB_GRANT_CNT_EN
    logic [NUM_REQ*CNT_W-1:0]  grant_count;
`endif

    always #5 clk = ~clk;

    line_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W)
`ifdef ARB_GRANT_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
`ifdef ARB_GRANT_CNT_EN
        , .grant_count(grant_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        r = '0;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Transaction-level model: who owns the port, who is being answered, where the scan starts.
    int                m_owner = -1;
    int                m_resp  = -1;
    int                m_rr    = 0;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata, m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_resp  = -1;
            m_rr    = 0;
        end else if (m_resp >= 0) begin
            m_resp = -1;
        end else if (m_owner >= 0) begin
            if (mem_resp) begin
                m_rdata = m_wr ? '0 : mem_rdata;
                m_resp  = m_owner;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_rr + k) % NUM_REQ;
                if (m_owner < 0 && (req_read[i] || req_write[i])) begin
                    m_owner = i;
                    m_wr    = req_write[i];
                    m_addr  = req_addr[i*ADDR_W +: ADDR_W];
                    m_wdata = req_wdata[i*LINE_W +: LINE_W];
                end
            end
            if (m_owner >= 0) m_rr = (m_owner + 1) % NUM_REQ;
        end
    end

    int dut_grants[$];
    int cmd_len = 0;
    int last_cmd_len = 0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_resp;
        #1;
        exp_resp = '0;
        if (m_resp >= 0) exp_resp[m_resp] = 1'b1;
        chk("mem_read",  mem_read,  (m_owner >= 0) && !m_wr);
        chk("mem_write", mem_write, (m_owner >= 0) && m_wr);
        chk("mem_addr",  mem_addr,  (m_owner >= 0) ? m_addr : '0);
        chk("mem_wdata", mem_wdata, (m_owner >= 0) ? m_wdata : '0);
        chk("req_resp",  req_resp,  exp_resp);
        chk("req_rdata", req_rdata, (m_resp >= 0) ? m_rdata : '0);
        if (!rst_n) cmd_len = 0;
        if (|req_resp) begin
            dut_grants.push_back(req_resp[1] ? 1 : 0);
            last_cmd_len = cmd_len;
            cmd_len = 0;
        end
        if (mem_read || mem_write) cmd_len++;
    end

    // Called on a falling edge; returns on the falling edge of the response cycle.
    task automatic mem_reply(input int cyc, input logic [LINE_W-1:0] d);
        int n;
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(mem_read || mem_write)) begin
            chk("cmd_timeout", 1'b0, 1'b1);
            return;
        end
        for (int c = 1; c < cyc; c++) @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] d, w;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_req_resp", req_resp, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray mem_resp while idle
        mem_resp = 1'b1; mem_rdata = {8{32'hDEADBEEF}};
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = '0;
        @(negedge clk); #2;
        chk("idle_resp_ignored", req_resp, 2'b00);

        // Single read, four-cycle memory
        d = rand_line();
        req_addr[0 +: ADDR_W] = 27'h123; req_read[0] = 1'b1;
        @(negedge clk);
        chk("t1_mem_addr", mem_addr, 27'h123);
        mem_reply(4, d); #2;
        chk("t1_resp", req_resp, 2'b01);
        chk("t1_rdata", req_rdata, d);
        chk("t1_cmd_len", last_cmd_len, 4);
        req_read = '0;
        @(negedge clk);

        // Both read, held, from reset
        do_reset();
        dut_grants.delete();
        req_addr = {27'h2222, 27'h1111}; req_read = 2'b11;
        for (int t = 0; t < 4; t++) mem_reply(2, rand_line());
        req_read = '0; #2;
        chk("t2_count", dut_grants.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < dut_grants.size()) chk($sformatf("t2_grant%0d", i), dut_grants[i], exp_order[i]);
        @(negedge clk);

        // Write from requester 1, immediate memory response
        w = rand_line();
        req_addr[ADDR_W +: ADDR_W] = 27'h7; req_wdata[LINE_W +: LINE_W] = w; req_write[1] = 1'b1;
        @(negedge clk);
        chk("t3_mem_write", mem_write, 1'b1);
        chk("t3_mem_wdata", mem_wdata, w);
        mem_reply(1, rand_line()); #2;
        chk("t3_resp", req_resp, 2'b10);
        chk("t3_rdata", req_rdata, '0);
        chk("t3_cmd_len", last_cmd_len, 1);
        req_write = '0;
        @(negedge clk);

        // Address changes while busy
        d = rand_line();
        req_addr[0 +: ADDR_W] = 27'h4AB; req_read[0] = 1'b1;
        @(negedge clk);
        req_addr[0 +: ADDR_W] = 27'h3FF; req_wdata[0 +: LINE_W] = rand_line();
        @(negedge clk);
        chk("t4_mem_addr", mem_addr, 27'h4AB);
        mem_reply(3, d); #2;
        chk("t4_resp", req_resp, 2'b01);
        chk("t4_rdata", req_rdata, d);
        req_read = '0;
        @(negedge clk);

        // Reset in the middle of a read
        req_addr[0 +: ADDR_W] = 27'h55; req_read[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; #1;
        chk("t5_mem_read", mem_read, 1'b0);
        chk("t5_req_resp", req_resp, 2'b00);
        @(negedge clk);
        rst_n = 1'b1; req_read = '0;
        req_addr[ADDR_W +: ADDR_W] = 27'h66; req_write[1] = 1'b1;
        @(negedge clk);
        chk("t5_mem_addr", mem_addr, 27'h66);
        mem_reply(2, rand_line()); #2;
        chk("t5_resp", req_resp, 2'b10);
        req_write = '0;
        @(negedge clk);

`ifdef ARB_GRANT_CNT_EN
        // Counter saturation
        do_reset();
        req_read[0] = 1'b1;
        for (int t = 0; t < 5; t++) mem_reply(1, rand_line());
        req_read = '0; #2;
        chk("t6_cnt0", grant_count[0 +: CNT_W], 2'd3);
        chk("t6_cnt1", grant_count[CNT_W +: CNT_W], 2'd0);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
